// File: rtl/peravg.sv
// Tap-period averager: DEPTH-entry sliding window with pass-through while filling,
// outlier rejection with forced re-seed, and flush on zero/timeout/clear handling.
module peravg #(
    parameter int PER_W        = 16,
    parameter int DEPTH_LOG2   = 2,
    parameter int REJECT_EN    = 1,
    parameter int REJECT_SHIFT = 2,
    parameter int REJECT_MAX   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PER_W-1:0]      per_i,
    input  logic                  per_valid_i,
    input  logic                  clear_i,
    output logic [PER_W-1:0]      avg_o,
    output logic                  avg_valid_o,
    output logic [DEPTH_LOG2:0]   fill_o,
    output logic                  rej_o,
    output logic                  ovr_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int SUM_W = PER_W + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_F = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [4:0] REJ_LIMIT = 5'(REJECT_MAX);

    typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_BUSY} state_t;

    state_t                  state_q, state_d;
    logic                    ret_run_q, ret_run_d;
    logic [PER_W-1:0]        newest_q, newest_d;
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
    logic [DEPTH_LOG2:0]     fill_q, fill_d;
    logic [3:0]              rej_cnt_q, rej_cnt_d;
    logic [PER_W-1:0]        avg_q, avg_d;
    logic                    avg_valid_q, avg_valid_d;
    logic                    rej_q, rej_d;
    logic                    ovr_q, ovr_d;

    logic [PER_W-1:0]        mem_q [DEPTH];
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_wa;
    logic [PER_W-1:0]        oldest;
    logic [PER_W-1:0]        sum_avg;

    // |s - a| > (a >> REJECT_SHIFT), evaluated with one guard bit so the difference cannot wrap
    function automatic logic is_outlier(input logic [PER_W-1:0] s, input logic [PER_W-1:0] a);
        logic signed [PER_W:0] diff;
        logic [PER_W:0]        mag;
        logic [PER_W-1:0]      thr;
        diff = signed'({1'b0, s}) - signed'({1'b0, a});
        mag  = (diff < 0) ? unsigned'(-diff) : unsigned'(diff);
        thr  = a >> REJECT_SHIFT;
        return mag > {1'b0, thr};
    endfunction

    assign oldest  = (fill_q == DEPTH_F) ? mem_q[ptr_q] : '0;
    assign sum_avg = sum_q[SUM_W-1:DEPTH_LOG2];

    always_comb begin
        state_d     = state_q;
        ret_run_d   = ret_run_q;
        newest_d    = newest_q;
        sum_d       = sum_q;
        ptr_d       = ptr_q;
        fill_d      = fill_q;
        rej_cnt_d   = rej_cnt_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        rej_d       = 1'b0;
        ovr_d       = 1'b0;
        mem_we      = 1'b0;
        mem_wa      = ptr_q;

        if (clear_i) begin
            state_d   = ST_FILL;
            sum_d     = '0;
            ptr_d     = '0;
            fill_d    = '0;
            rej_cnt_d = '0;
        end else if (state_q == ST_BUSY) begin
            // second half of an update: publish the result and return
            avg_valid_d = 1'b1;
            avg_d       = ret_run_q ? sum_avg : newest_q;
            state_d     = ret_run_q ? ST_RUN : ST_FILL;
            ovr_d       = per_valid_i;
        end else if (per_valid_i && (per_i != '0)) begin
            if (per_i == '1) begin
                state_d   = ST_FILL;
                sum_d     = '0;
                ptr_d     = '0;
                fill_d    = '0;
                rej_cnt_d = '0;
            end else if ((REJECT_EN != 0) && (state_q == ST_RUN) && is_outlier(per_i, avg_q)) begin
                rej_d = 1'b1;
                if (({1'b0, rej_cnt_q} + 5'd1) >= REJ_LIMIT) begin
                    // persistent outliers: restart the window from this sample
                    mem_we    = 1'b1;
                    mem_wa    = '0;
                    sum_d     = SUM_W'(per_i);
                    ptr_d     = DEPTH_LOG2'(1);
                    fill_d    = (DEPTH_LOG2 + 1)'(1);
                    rej_cnt_d = '0;
                    newest_d  = per_i;
                    ret_run_d = 1'b0;
                    state_d   = ST_BUSY;
                end else begin
                    rej_cnt_d = rej_cnt_q + 4'd1;
                end
            end else begin
                mem_we    = 1'b1;
                sum_d     = sum_q + SUM_W'(per_i) - SUM_W'(oldest);
                ptr_d     = ptr_q + DEPTH_LOG2'(1);
                fill_d    = (fill_q == DEPTH_F) ? fill_q : fill_q + (DEPTH_LOG2 + 1)'(1);
                rej_cnt_d = '0;
                newest_d  = per_i;
                ret_run_d = (fill_d == DEPTH_F);
                state_d   = ST_BUSY;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_FILL;
            ret_run_q   <= 1'b0;
            sum_q       <= '0;
            ptr_q       <= '0;
            fill_q      <= '0;
            rej_cnt_q   <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            rej_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_run_q   <= ret_run_d;
            sum_q       <= sum_d;
            ptr_q       <= ptr_d;
            fill_q      <= fill_d;
            rej_cnt_q   <= rej_cnt_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            rej_q       <= rej_d;
            ovr_q       <= ovr_d;
        end
    end

    // window storage and pass-through sample carry no reset
    always_ff @(posedge clk_i) begin
        newest_q <= newest_d;
        if (mem_we) begin
            mem_q[mem_wa] <= per_i;
        end
    end

    assign avg_o       = avg_q;
    assign avg_valid_o = avg_valid_q;
    assign fill_o      = fill_q;
    assign rej_o       = rej_q;
    assign ovr_o       = ovr_q;

endmodule

// File: tb/tb_peravg.sv
// Directed bench for peravg with default parameters (PER_W=16, DEPTH=4, shift 2, max 3).
module tb_peravg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] per;
    logic        per_valid;
    logic        clear;
    logic [15:0] avg;
    logic        avg_valid;
    logic [2:0]  fill;
    logic        rej;
    logic        ovr;

    int total = 0;
    int bad   = 0;

    peravg dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .per_i       (per),
        .per_valid_i (per_valid),
        .clear_i     (clear),
        .avg_o       (avg),
        .avg_valid_o (avg_valid),
        .fill_o      (fill),
        .rej_o       (rej),
        .ovr_o       (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe in cycle N, then check cycle N+1 and N+2, then idle to 10-cycle spacing
    task automatic send(input string tag, input logic [15:0] v, input logic exp_valid,
                        input logic [15:0] exp_avg, input logic [2:0] exp_fill,
                        input logic exp_rej);
        tick();
        per = v;
        per_valid = 1'b1;
        tick();
        per_valid = 1'b0;
        chk({tag, ".n1_rej"}, 32'(rej), 32'(exp_rej));
        chk({tag, ".n1_valid"}, 32'(avg_valid), 32'd0);
        chk({tag, ".n1_ovr"}, 32'(ovr), 32'd0);
        tick();
        chk({tag, ".n2_valid"}, 32'(avg_valid), 32'(exp_valid));
        chk({tag, ".n2_avg"}, 32'(avg), 32'(exp_avg));
        chk({tag, ".n2_fill"}, 32'(fill), 32'(exp_fill));
        chk({tag, ".n2_rej"}, 32'(rej), 32'd0);
        tick();
        chk({tag, ".n3_valid"}, 32'(avg_valid), 32'd0);
        repeat (6) tick();
    endtask

    initial begin
        rst = 1'b1;
        per = '0;
        per_valid = 1'b0;
        clear = 1'b0;
        repeat (2) tick();
        chk("rst.avg", 32'(avg), 32'd0);
        chk("rst.valid", 32'(avg_valid), 32'd0);
        chk("rst.fill", 32'(fill), 32'd0);
        chk("rst.rej", 32'(rej), 32'd0);
        chk("rst.ovr", 32'(ovr), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // fill the window with a constant period
        send("fill1", 16'd1000, 1'b1, 16'd1000, 3'd1, 1'b0);
        send("fill2", 16'd1000, 1'b1, 16'd1000, 3'd2, 1'b0);
        send("fill3", 16'd1000, 1'b1, 16'd1000, 3'd3, 1'b0);
        send("fill4", 16'd1000, 1'b1, 16'd1000, 3'd4, 1'b0);

        // (1000*3 + 1200) / 4 = 1050; 2000 is 950 away, threshold 262
        send("run1200", 16'd1200, 1'b1, 16'd1050, 3'd4, 1'b0);
        send("rej1", 16'd2000, 1'b0, 16'd1050, 3'd4, 1'b1);
        send("rej2", 16'd2000, 1'b0, 16'd1050, 3'd4, 1'b1);
        send("rej3seed", 16'd2000, 1'b1, 16'd2000, 3'd1, 1'b1);

        send("zero", 16'd0, 1'b0, 16'd2000, 3'd1, 1'b0);

        send("refill2", 16'd2000, 1'b1, 16'd2000, 3'd2, 1'b0);
        send("refill3", 16'd2000, 1'b1, 16'd2000, 3'd3, 1'b0);
        send("refill4", 16'd2000, 1'b1, 16'd2000, 3'd4, 1'b0);

        send("timeout", 16'hFFFF, 1'b0, 16'd2000, 3'd0, 1'b0);
        send("after_to", 16'd800, 1'b1, 16'd800, 3'd1, 1'b0);

        // back-to-back strobes: second one lands while busy
        tick();
        per = 16'd500;
        per_valid = 1'b1;
        tick();
        per = 16'd600;
        chk("b2b.n1_ovr", 32'(ovr), 32'd0);
        tick();
        per_valid = 1'b0;
        chk("b2b.n2_valid", 32'(avg_valid), 32'd1);
        chk("b2b.n2_avg", 32'(avg), 32'd500);
        chk("b2b.n2_fill", 32'(fill), 32'd2);
        chk("b2b.n2_ovr", 32'(ovr), 32'd1);
        tick();
        chk("b2b.n3_ovr", 32'(ovr), 32'd0);
        chk("b2b.n3_valid", 32'(avg_valid), 32'd0);
        repeat (6) tick();
        send("fill700", 16'd700, 1'b1, 16'd700, 3'd3, 1'b0);
        // (800 + 500 + 700 + 900) / 4 = 725; 600 must not be in the sum
        send("fill900", 16'd900, 1'b1, 16'd725, 3'd4, 1'b0);

        // clear together with a strobe
        tick();
        per = 16'd1234;
        per_valid = 1'b1;
        clear = 1'b1;
        tick();
        per_valid = 1'b0;
        clear = 1'b0;
        chk("clr.n1_fill", 32'(fill), 32'd0);
        chk("clr.n1_ovr", 32'(ovr), 32'd0);
        chk("clr.n1_valid", 32'(avg_valid), 32'd0);
        tick();
        chk("clr.n2_valid", 32'(avg_valid), 32'd0);
        chk("clr.n2_ovr", 32'(ovr), 32'd0);
        chk("clr.n2_avg", 32'(avg), 32'd725);
        repeat (4) tick();
        send("post_clr", 16'd1000, 1'b1, 16'd1000, 3'd1, 1'b0);

        // reset one cycle after a strobe cancels the update
        tick();
        per = 16'd1234;
        per_valid = 1'b1;
        tick();
        per_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid.valid", 32'(avg_valid), 32'd0);
        chk("rstmid.avg", 32'(avg), 32'd0);
        chk("rstmid.fill", 32'(fill), 32'd0);
        chk("rstmid.ovr", 32'(ovr), 32'd0);
        tick();
        chk("rstmid.n3_valid", 32'(avg_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peravg.md
PERAVG -- requirements
Module: peravg

Interface
REQ-001 Parameter PER_W, 16, width of tap-period samples and average, in timepulse units.
REQ-002 Parameter DEPTH_LOG2, 2, log2 of averaging window depth (DEPTH = 2**DEPTH_LOG2), range 1..4.
REQ-003 Parameter REJECT_EN, 1, 1 enables outlier rejection, 0 accepts every valid sample.
REQ-004 Parameter REJECT_SHIFT, 2, outlier threshold = avg_o >> REJECT_SHIFT.
REQ-005 Parameter REJECT_MAX, 3, consecutive rejects that force a history flush, range 1..15.
REQ-006 clk_i  input  1  single clock; all logic on its rising edge.
REQ-007 rst_i  input  1  synchronous, active-high reset.
REQ-008 per_i  input  PER_W  tap period sample from period counter.
REQ-009 per_valid_i  input  1  one-cycle strobe qualifying per_i.
REQ-010 clear_i  input  1  synchronous history flush request.
REQ-011 avg_o  output  PER_W  registered averaged period.
REQ-012 avg_valid_o  output  1  one-cycle strobe when avg_o updates.
REQ-013 fill_o  output  DEPTH_LOG2+1  number of samples held in the window.
REQ-014 rej_o  output  1  one-cycle strobe: sample rejected as outlier.
REQ-015 ovr_o  output  1  one-cycle strobe: sample dropped because block busy.

Function
REQ-016 The block SHALL hold a DEPTH-entry ring buffer, a write pointer, a running sum of width PER_W+DEPTH_LOG2, and a reject counter.
REQ-017 FSM states SHALL be FILL (fill_o < DEPTH), RUN (fill_o = DEPTH), and BUSY (2-cycle update in progress, return state remembered).
REQ-018 A sample accepted at cycle N SHALL update buffer/sum at N+1 and drive avg_o with avg_valid_o high at N+2; latency exactly 2 cycles.
REQ-019 Update rule: sum <= sum + per_i - oldest entry (oldest = 0 in FILL); entry at write pointer <= per_i; pointer wraps modulo DEPTH.
REQ-020 In FILL, avg_o SHALL equal the newest sample (pass-through); fill_o increments; at fill_o = DEPTH FSM enters RUN.
REQ-021 In RUN, avg_o SHALL equal sum >> DEPTH_LOG2 (truncating).
REQ-022 In RUN with REJECT_EN=1, a sample with |per_i - avg_o| > (avg_o >> REJECT_SHIFT) SHALL be rejected: no buffer/sum/avg_o change, no avg_valid_o, rej_o pulses at N+1, reject counter increments.
REQ-023 An accepted sample SHALL clear the reject counter.
REQ-024 The REJECT_MAX-th consecutive reject SHALL flush the history and seed it with that sample: fill_o = 1, FSM = FILL, avg_o = per_i, avg_valid_o at N+2, rej_o pulses, counter cleared.
REQ-025 No rejection SHALL occur in FILL or when REJECT_EN=0.
REQ-026 per_i = 0 SHALL be ignored (no strobes, no state change).
REQ-027 per_i = all-ones (counter saturation / timeout) SHALL flush history: fill_o = 0, FSM = FILL, avg_o held, no avg_valid_o.
REQ-028 per_valid_i while BUSY SHALL drop the sample and pulse ovr_o the next cycle; the in-flight update completes unaffected.
REQ-029 clear_i SHALL flush history next cycle (fill_o, sum, pointer, reject counter to 0; FSM = FILL; avg_o held); it aborts any in-flight update (no avg_valid_o).
REQ-030 clear_i and per_valid_i in the same cycle: clear wins, sample discarded, no ovr_o.
REQ-031 Buffer contents beyond fill_o SHALL never affect sum or avg_o.

Reset
REQ-032 rst_i high SHALL, at the next clock edge, set avg_o = 0, avg_valid_o = 0, fill_o = 0, rej_o = 0, ovr_o = 0, sum = 0, pointer = 0, reject counter = 0, FSM = FILL.
REQ-033 Reset asserted mid-update SHALL cancel that update with no strobe output.
REQ-034 Ring buffer storage SHALL not require reset.

Verification (PER_W=16, DEPTH_LOG2=2, REJECT_SHIFT=2, REJECT_MAX=3)
REQ-035 Four samples 1000 spaced 10 cycles -> four avg_valid_o pulses, avg_o = 1000, fill_o 1,2,3,4, each pulse exactly 2 cycles after its strobe.
REQ-036 Then sample 1200 -> accepted, avg_o = 1050; then 2000 -> rej_o pulse, avg_o stays 1050, no avg_valid_o.
REQ-037 Then 2000 twice more -> second rej_o only; third-in-row flushes: fill_o = 1, avg_o = 2000, avg_valid_o and rej_o pulse.
REQ-038 In RUN, sample 0xFFFF -> fill_o = 0, avg_o held, no strobe; next sample 800 -> avg_o = 800, fill_o = 1.
REQ-039 Two per_valid_i strobes one cycle apart (500, 600) -> 500 processed, ovr_o pulses once, 600 absent from sum.
REQ-040 clear_i with per_valid_i same cycle, and rst_i one cycle after a strobe -> no avg_valid_o, no ovr_o, fill_o = 0, avg_o held for clear, avg_o = 0 for reset.
